// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared constants and channel state type for the divider bank
package clk_div_pkg;
   localparam int CNT_W_DEF = 22;
   typedef enum logic [1:0] {IDLE, LOW, HIGH} chan_state_t;
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divide-by-2M channel with shadowed divisor and edge strobes
module clk_div_chan
   import clk_div_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             sync,
   input  logic [CNT_W-1:0] maxcount,
   input  logic             load,
   output logic             sclk,
   output logic             rise,
   output logic             fall,
   output logic             busy
);
   chan_state_t state, state_n;
   logic [CNT_W-1:0] shadow, active, count, active_n, count_n;
   logic rise_n, fall_n, wrap;
   assign wrap = count == active - CNT_W'(1);
   assign sclk = state == HIGH;
   assign busy = state != IDLE;
   always_comb begin
      state_n  = state;
      active_n = active;
      count_n  = count;
      rise_n   = 1'b0;
      fall_n   = 1'b0;
      if (sync && state != IDLE) begin
         count_n  = '0;
         fall_n   = state == HIGH;
         state_n  = shadow == '0 ? IDLE : LOW;
         active_n = shadow;
      end else if (state == IDLE) begin
         if (en && shadow != '0) begin
            state_n  = LOW;
            active_n = shadow;
            count_n  = '0;
         end
      end else if (en) begin
         if (wrap) begin
            count_n = '0;
            if (state == LOW) begin
               state_n = HIGH;
               rise_n  = 1'b1;
            end else begin
               // The period boundary is the only place a new divisor is adopted.
               fall_n   = 1'b1;
               state_n  = shadow == '0 ? IDLE : LOW;
               active_n = shadow;
            end
         end else begin
            count_n = count + CNT_W'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         shadow <= '0;
         active <= '0;
         count  <= '0;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         state  <= state_n;
         active <= active_n;
         count  <= count_n;
         rise   <= rise_n;
         fall   <= fall_n;
         if (load) shadow <= maxcount;
      end
   end
endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank: NUM_CH independent programmable clock dividers sharing one sync
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH-1:0]       en,
   input  logic                    sync,
   input  logic [NUM_CH*CNT_W-1:0] maxcount,
   input  logic [NUM_CH-1:0]       load,
   output logic [NUM_CH-1:0]       sclk,
   output logic [NUM_CH-1:0]       rise,
   output logic [NUM_CH-1:0]       fall,
   output logic [NUM_CH-1:0]       busy
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      clk_div_chan #(.CNT_W(CNT_W)) u_chan (
         .clk      (clk),
         .rst      (rst),
         .en       (en[i]),
         .sync     (sync),
         .maxcount (maxcount[i*CNT_W +: CNT_W]),
         .load     (load[i]),
         .sclk     (sclk[i]),
         .rise     (rise[i]),
         .fall     (fall[i]),
         .busy     (busy[i])
      );
   end
endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank: directed checks of the divider bank against hand-computed waveforms
module tb_clk_div_bank;
   localparam int N  = 4;
   localparam int CW = 8;
   logic clk = 1'b0;
   logic rst, sync;
   logic [N-1:0] en, load, sclk, rise, fall, busy;
   logic [N*CW-1:0] maxcount;
   int checks = 0;
   int errors = 0;
   clk_div_bank #(.NUM_CH(N), .CNT_W(CW)) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .sync     (sync),
      .maxcount (maxcount),
      .load     (load),
      .sclk     (sclk),
      .rise     (rise),
      .fall     (fall),
      .busy     (busy)
   );
   always #5 clk = ~clk;
   task step;
      @(posedge clk);
      #1;
   endtask
   task do_reset;
      rst = 1'b1; en = '0; load = '0; sync = 1'b0; maxcount = '0;
      step;
      rst = 1'b0;
   endtask
   task start_ch(input int c, input int m);
      maxcount[c*CW +: CW] = CW'(m);
      load[c] = 1'b1;
      step;
      load[c] = 1'b0;
      en[c] = 1'b1;
      step;
   endtask
   task test_reset;
      rst = 1'b1; en = '1; load = '1; sync = 1'b1; maxcount = '1;
      step;
      checks++;
      if ({sclk, rise, fall, busy} !== '0) begin
         errors++;
         $display("FAIL reset: got %h want 0", {sclk, rise, fall, busy});
      end
      rst = 1'b0; en = '0; load = '0; sync = 1'b0;
      step;
      checks++;
      if (busy !== '0) begin
         errors++;
         $display("FAIL reset_busy: got %b want 0000", busy);
      end
   endtask
   task test_start;
      do_reset;
      start_ch(0, 3);
      checks++;
      if ({busy[0], sclk[0], rise[0], fall[0]} !== 4'b1000) begin
         errors++;
         $display("FAIL start_low: got %b want 1000", {busy[0], sclk[0], rise[0], fall[0]});
      end
      step; step; step;
      for (int t = 0; t < 13; t++) begin
         checks++;
         if ({sclk[0], rise[0], fall[0]} !== {t % 6 < 3, t % 6 == 0, t % 6 == 3}) begin
            errors++;
            $display("FAIL start_t%0d: got %b want %b", t, {sclk[0], rise[0], fall[0]},
                     {t % 6 < 3, t % 6 == 0, t % 6 == 3});
         end
         step;
      end
   endtask
   task test_min_div;
      do_reset;
      start_ch(1, 1);
      step;
      for (int t = 0; t < 8; t++) begin
         checks++;
         if ({sclk[1], rise[1], fall[1]} !== (t % 2 == 0 ? 3'b110 : 3'b001)) begin
            errors++;
            $display("FAIL min_div_t%0d: got %b want %b", t, {sclk[1], rise[1], fall[1]},
                     t % 2 == 0 ? 3'b110 : 3'b001);
         end
         step;
      end
   endtask
   task test_reload;
      logic [23:0] seq;
      seq = {3'b100, 3'b100, 3'b001, 3'b000, 3'b110, 3'b100, 3'b001, 3'b000};
      do_reset;
      start_ch(0, 4);
      repeat (4) step;
      checks++;
      if ({sclk[0], rise[0]} !== 2'b11) begin
         errors++;
         $display("FAIL reload_rise: got %b want 11", {sclk[0], rise[0]});
      end
      maxcount[0 +: CW] = CW'(2);
      load[0] = 1'b1;
      step;
      load[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         step;
         checks++;
         if ({sclk[0], rise[0], fall[0]} !== seq[23-3*k -: 3]) begin
            errors++;
            $display("FAIL reload_k%0d: got %b want %b", k, {sclk[0], rise[0], fall[0]},
                     seq[23-3*k -: 3]);
         end
      end
   endtask
   task test_freeze;
      do_reset;
      start_ch(2, 5);
      step; step;
      en[2] = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step;
         checks++;
         if ({busy[2], sclk[2], rise[2], fall[2]} !== 4'b1000) begin
            errors++;
            $display("FAIL freeze_k%0d: got %b want 1000", k, {busy[2], sclk[2], rise[2], fall[2]});
         end
      end
      en[2] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step;
         checks++;
         if ({sclk[2], rise[2]} !== (k == 2 ? 2'b11 : 2'b00)) begin
            errors++;
            $display("FAIL resume_k%0d: got %b want %b", k, {sclk[2], rise[2]},
                     k == 2 ? 2'b11 : 2'b00);
         end
      end
   endtask
   task test_sync;
      do_reset;
      maxcount[0 +: CW] = CW'(3);
      maxcount[CW +: CW] = CW'(3);
      load = 4'b0011;
      step;
      load = '0;
      en = 4'b0001;
      step;
      en = 4'b0011;
      step; step; step;
      checks++;
      if (sclk[1:0] !== 2'b01) begin
         errors++;
         $display("FAIL sync_pre: got %b want 01", sclk[1:0]);
      end
      sync = 1'b1;
      step;
      sync = 1'b0;
      checks++;
      if ({sclk[1:0], rise[1:0], fall[1:0]} !== 6'b000001) begin
         errors++;
         $display("FAIL sync_align: got %b want 000001", {sclk[1:0], rise[1:0], fall[1:0]});
      end
      for (int k = 0; k < 3; k++) begin
         step;
         checks++;
         if ({sclk[1:0], rise[1:0]} !== (k == 2 ? 4'b1111 : 4'b0000)) begin
            errors++;
            $display("FAIL sync_k%0d: got %b want %b", k, {sclk[1:0], rise[1:0]},
                     k == 2 ? 4'b1111 : 4'b0000);
         end
      end
   endtask
   task test_shutdown;
      do_reset;
      start_ch(3, 2);
      step; step;
      maxcount[3*CW +: CW] = '0;
      load[3] = 1'b1;
      step;
      load[3] = 1'b0;
      checks++;
      if ({busy[3], sclk[3], fall[3]} !== 3'b110) begin
         errors++;
         $display("FAIL shut_high: got %b want 110", {busy[3], sclk[3], fall[3]});
      end
      step;
      checks++;
      if ({busy[3], sclk[3], fall[3]} !== 3'b001) begin
         errors++;
         $display("FAIL shut_fall: got %b want 001", {busy[3], sclk[3], fall[3]});
      end
      step;
      checks++;
      if ({busy[3], sclk[3], rise[3], fall[3]} !== 4'b0000) begin
         errors++;
         $display("FAIL shut_idle: got %b want 0000", {busy[3], sclk[3], rise[3], fall[3]});
      end
   endtask
   task test_reset_mid;
      do_reset;
      start_ch(0, 3);
      step; step; step;
      checks++;
      if (sclk[0] !== 1'b1) begin
         errors++;
         $display("FAIL mid_high: got %b want 1", sclk[0]);
      end
      rst = 1'b1;
      step;
      checks++;
      if ({sclk, rise, fall, busy} !== '0) begin
         errors++;
         $display("FAIL mid_reset: got %h want 0", {sclk, rise, fall, busy});
      end
      rst = 1'b0;
      step;
      checks++;
      if (busy[0] !== 1'b0) begin
         errors++;
         $display("FAIL mid_shadow: got %b want 0", busy[0]);
      end
   endtask
   task test_max_div;
      do_reset;
      start_ch(2, 255);
      repeat (254) step;
      checks++;
      if ({sclk[2], rise[2]} !== 2'b00) begin
         errors++;
         $display("FAIL max_low: got %b want 00", {sclk[2], rise[2]});
      end
      step;
      checks++;
      if ({sclk[2], rise[2]} !== 2'b11) begin
         errors++;
         $display("FAIL max_rise: got %b want 11", {sclk[2], rise[2]});
      end
      repeat (254) step;
      checks++;
      if ({sclk[2], fall[2]} !== 2'b10) begin
         errors++;
         $display("FAIL max_high: got %b want 10", {sclk[2], fall[2]});
      end
      step;
      checks++;
      if ({sclk[2], fall[2]} !== 2'b01) begin
         errors++;
         $display("FAIL max_fall: got %b want 01", {sclk[2], fall[2]});
      end
   endtask
   initial begin
      rst = 1'b1; en = '0; load = '0; sync = 1'b0; maxcount = '0;
      test_reset;
      test_start;
      test_min_div;
      test_reload;
      test_freeze;
      test_sync;
      test_shutdown;
      test_reset_mid;
      test_max_div;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
- Multi-channel programmable clock-enable/divider bank.
- Each channel divides clk by 2*M, where M is a runtime divisor per channel, and produces a square-wave sclk plus single-cycle edge strobes.
- Divisor updates are glitch-free: a new value takes effect only at a period boundary.
- Feeds display multiplexing, debouncers and slow-tick logic from one shared instance.

Parameters:
- NUM_CH, 4, number of independent divider channels (1..16).
- CNT_W, 22, width of each divisor and its counter.

Ports:
- clk  in  1  system clock; all logic is on posedge clk.
- rst  in  1  synchronous, active-high reset.
- en  in  NUM_CH  per-channel run enable.
- sync  in  1  single-cycle phase-align strobe for all channels.
- maxcount  in  NUM_CH*CNT_W  per-channel divisor M; channel i uses bits [i*CNT_W +: CNT_W].
- load  in  NUM_CH  per-channel strobe that captures maxcount into that channel's shadow register.
- sclk  out  NUM_CH  divided square wave, period 2*M clk cycles, 50% duty.
- rise  out  NUM_CH  1-cycle pulse in the cycle sclk goes 0->1.
- fall  out  NUM_CH  1-cycle pulse in the cycle sclk goes 1->0.
- busy  out  NUM_CH  1 when the channel is actively dividing (state LOW or HIGH).

Behaviour:
- Reset (rst=1 at posedge clk):
  - count=0, sclk=0, rise=0, fall=0, busy=0, state=IDLE.
  - Shadow and active divisors = 0.
  - rst overrides sync, load and en.
- Per-channel registers:
  - shadow[CNT_W]: captured on load.
  - active[CNT_W]: the divisor in use.
  - count[CNT_W].
  - state: IDLE / LOW / HIGH (sclk=0 in IDLE and LOW, sclk=1 in HIGH).
- IDLE -> LOW:
  - Condition: en=1 and shadow!=0.
  - Actions: active<=shadow, count<=0.
  - sclk stays 0; no strobe.
- LOW/HIGH, en=1:
  - count increments each cycle.
  - When count==active-1: count<=0 and the state toggles.
  - Entering HIGH: sclk<=1 and rise=1 for that cycle.
  - Entering LOW: sclk<=0 and fall=1 for that cycle.
  - Each level therefore lasts exactly M cycles.
- Divisor reload:
  - On a HIGH->LOW transition, if shadow!=active, active<=shadow.
  - No mid-period change is ever visible on sclk.
  - If shadow==0 at that boundary, the channel goes to IDLE (sclk=0, fall=1 still emitted).
- en=0 in LOW/HIGH: count, state and sclk freeze; no strobes; busy stays 1. Resumes where it stopped when en returns.
- en=0 in IDLE: stays IDLE.
- load:
  - Writes shadow the same cycle; visible in shadow on the next cycle.
  - If load and a HIGH->LOW boundary occur in the same cycle, the boundary uses the old shadow; the new value applies at the next boundary.
- sync=1, all channels:
  - count<=0.
  - Channels in HIGH go to LOW with sclk<=0 and fall=1; channels in LOW stay LOW.
  - active<=shadow, or IDLE if shadow==0.
  - sync takes priority over normal counting in the same cycle.
- M=1: sclk toggles every cycle (period 2); rise and fall alternate every cycle.
- M=2^CNT_W-1: count reaches all-ones-minus-one then wraps to 0; no overflow path exists.
- Strobes are registered: rise/fall are asserted in the same cycle sclk changes. Latency from load to first rise is at least M cycles.

Decomposition:
- Package clk_div_pkg:
  - default CNT_W constant.
  - chan_state_t enum {IDLE, LOW, HIGH}.
- Sub-module clk_div_chan:
  - One channel: shadow/active/count/state logic.
  - Ports: clk, rst, en, sync, maxcount, load, sclk, rise, fall, busy.
- clk_div_bank is a generate loop of NUM_CH clk_div_chan instances plus maxcount slicing.

Test Plan:
- Reset then start: rst, then load ch0 with 3 and en=1 -> sclk0 period 6, high 3 and low 3; rise0 every 6 cycles; first rise 3 cycles after entering LOW.
- Minimum divisor: M=1 on ch1 -> sclk1 toggles every cycle; rise1/fall1 alternate.
- Glitch-free reload: ch0 M=4 running; load 2 while HIGH -> current HIGH lasts 4 cycles, then subsequent levels last 2 cycles each.
- Enable freeze: freeze (en=0) for 5 cycles mid-LOW on ch2 with M=5 -> sclk2 holds and no strobes; the remaining LOW count resumes exactly on re-enable.
- Phase align: ch0 M=3 and ch1 M=3 out of phase; pulse sync -> both sclk=0 next cycle, then rise together 3 cycles later.
- Shutdown and reset mid-operation:
  - load 0 while running -> channel completes the period, emits fall, goes IDLE, busy=0.
  - rst asserted while HIGH -> all outputs 0 next cycle.
